// File: rtl/fixed_msa_head_gather.sv
// Joins skewed per-head attention streams into one row-major beat.
// Per-head FWFT FIFOs, runtime head mask, and block framing.
module fixed_msa_head_gather #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_HEADS     = 2,
  parameter int UNROLL_IN_Y   = 1,
  parameter int UNROLL_WQKV_Y = 1,
  parameter int ITER_IN_Y     = 6,
  parameter int ITER_WQKV_Y   = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_HEADS*UNROLL_IN_Y*UNROLL_WQKV_Y*DATA_WIDTH-1:0] head_in,
  input  logic [NUM_HEADS-1:0] head_in_valid,
  output logic [NUM_HEADS-1:0] head_in_ready,
  input  logic [NUM_HEADS-1:0] head_enable,
  output logic [UNROLL_IN_Y*NUM_HEADS*UNROLL_WQKV_Y*DATA_WIDTH-1:0] data_out,
  output logic data_out_valid,
  input  logic data_out_ready,
  output logic data_out_last
);

  localparam int HP    = UNROLL_IN_Y * UNROLL_WQKV_Y;
  localparam int BEATS = ITER_IN_Y * ITER_WQKV_Y;
  localparam int LW    = HP * DATA_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LW-1:0] mem [NUM_HEADS][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_HEADS];
  logic [AW-1:0] rd_ptr [NUM_HEADS];
  logic [AW:0]   count  [NUM_HEADS];

  logic [NUM_HEADS-1:0] head_mask;
  logic [NUM_HEADS-1:0] new_mask;
  logic [NUM_HEADS-1:0] empty;
  logic [NUM_HEADS-1:0] full;
  logic [NUM_HEADS-1:0] push;
  logic [NUM_HEADS-1:0] pop;
  logic [NUM_HEADS-1:0] flush;
  logic [CW-1:0]        beat_cnt;
  logic                 fire;
  logic                 latch;
  logic                 at_end;

  // FIFO status, handshakes, mask latch and framing
  always_comb begin
    empty         = '0;
    full          = '0;
    head_in_ready = '0;
    push          = '0;
    for (int h = 0; h < NUM_HEADS; h++) begin
      empty[h]         = (count[h] == '0);
      full[h]          = (count[h] == (AW+1)'(FIFO_DEPTH));
      head_in_ready[h] = !head_mask[h] || !full[h];
      push[h]          = head_in_valid[h] && head_mask[h] && !full[h];
    end
    data_out_valid = &(~head_mask | ~empty);
    fire           = data_out_valid && data_out_ready;
    pop            = {NUM_HEADS{fire}} & head_mask;
    at_end         = (beat_cnt == CW'(BEATS - 1));
    data_out_last  = data_out_valid && at_end;
    latch          = (beat_cnt == '0) && !fire;
    new_mask       = (head_enable == '0) ? '1 : head_enable;
    flush          = latch ? ~new_mask : '0;
  end

  // Transposed concatenation of FIFO heads; masked heads read as zero
  always_comb begin
    data_out = '0;
    if (data_out_valid) begin
      for (int i = 0; i < UNROLL_IN_Y; i++) begin
        for (int h = 0; h < NUM_HEADS; h++) begin
          for (int k = 0; k < UNROLL_WQKV_Y; k++) begin
            if (head_mask[h]) begin
              data_out[((i*NUM_HEADS+h)*UNROLL_WQKV_Y+k)*DATA_WIDTH +: DATA_WIDTH] =
                mem[h][rd_ptr[h]][(i*UNROLL_WQKV_Y+k)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  // FIFO storage writes (no reset needed, guarded by occupancy)
  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HEADS; h++) begin
      if (push[h]) begin
        mem[h][wr_ptr[h]] <= head_in[h*LW +: LW];
      end
    end
  end

  // FIFO pointers and occupancy; flush overrides push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HEADS; h++) begin
        wr_ptr[h] <= '0;
        rd_ptr[h] <= '0;
        count[h]  <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HEADS; h++) begin
        if (flush[h]) begin
          wr_ptr[h] <= '0;
          rd_ptr[h] <= '0;
          count[h]  <= '0;
        end else begin
          if (push[h]) wr_ptr[h] <= wr_ptr[h] + 1'b1;
          if (pop[h])  rd_ptr[h] <= rd_ptr[h] + 1'b1;
          count[h] <= count[h] + (AW+1)'(push[h]) - (AW+1)'(pop[h]);
        end
      end
    end
  end

  // Head mask latch at block boundary and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_mask <= '1;
      beat_cnt  <= '0;
    end else begin
      if (latch) head_mask <= new_mask;
      if (fire)  beat_cnt <= at_end ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_msa_head_gather.sv
// Randomized bench for fixed_msa_head_gather.
// Queue-level reference model of heads, mask and framing.
module tb_fixed_msa_head_gather;

  localparam int DW    = 8;
  localparam int NH    = 2;
  localparam int UY    = 1;
  localparam int UW    = 1;
  localparam int IY    = 6;
  localparam int IW    = 6;
  localparam int DEPTH = 4;
  localparam int HP    = UY * UW;
  localparam int LW    = HP * DW;
  localparam int BEATS = IY * IW;
  localparam int OW    = UY * NH * UW * DW;

  typedef logic [LW-1:0] elem_t;

  logic clk = 0;
  logic rst = 1;
  logic [NH*LW-1:0] head_in = '0;
  logic [NH-1:0] head_in_valid = '0;
  logic [NH-1:0] head_in_ready;
  logic [NH-1:0] head_enable = '1;
  logic [OW-1:0] data_out;
  logic data_out_valid;
  logic data_out_ready = 0;
  logic data_out_last;

  int n_checks = 0;
  int n_fail = 0;
  int hs_total = 0;
  int last_seen = 0;

  elem_t q [NH][$];
  logic [NH-1:0] m_mask;
  int m_beat;

  fixed_msa_head_gather #(
    .DATA_WIDTH(DW), .NUM_HEADS(NH),
    .UNROLL_IN_Y(UY), .UNROLL_WQKV_Y(UW),
    .ITER_IN_Y(IY), .ITER_WQKV_Y(IW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .head_in(head_in),
    .head_in_valid(head_in_valid),
    .head_in_ready(head_in_ready),
    .head_enable(head_enable),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last(data_out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) q[h].delete();
    m_mask = '1;
    m_beat = 0;
  endtask

  function automatic logic exp_valid();
    logic v = 1;
    for (int h = 0; h < NH; h++)
      if (m_mask[h] && q[h].size() == 0) v = 0;
    return v;
  endfunction

  task automatic check_outputs();
    logic v;
    logic [OW-1:0] d;
    logic [NH-1:0] r;
    elem_t e;
    v = exp_valid();
    d = '0;
    for (int h = 0; h < NH; h++) begin
      r[h] = !m_mask[h] || (q[h].size() < DEPTH);
      e = (m_mask[h] && q[h].size() > 0) ? q[h][0] : '0;
      for (int i = 0; i < UY; i++)
        for (int k = 0; k < UW; k++)
          d[((i*NH+h)*UW+k)*DW +: DW] = e[(i*UW+k)*DW +: DW];
    end
    check("valid", 64'(data_out_valid), 64'(v));
    check("last", 64'(data_out_last),
          64'(v && (m_beat == BEATS-1)));
    check("in_ready", 64'(head_in_ready), 64'(r));
    if (v) check("data", 64'(data_out), 64'(d));
  endtask

  task automatic model_update();
    logic hs;
    logic [NH-1:0] nm;
    hs = exp_valid() && data_out_ready;
    for (int h = 0; h < NH; h++) begin
      logic room;
      room = q[h].size() < DEPTH;
      if (hs && m_mask[h]) void'(q[h].pop_front());
      if (head_in_valid[h] && m_mask[h] && room)
        q[h].push_back(head_in[h*LW +: LW]);
    end
    if (m_beat == 0 && !hs) begin
      nm = (head_enable == '0) ? '1 : head_enable;
      for (int h = 0; h < NH; h++)
        if (!nm[h]) q[h].delete();
      m_mask = nm;
    end
    if (hs) begin
      hs_total++;
      if (m_beat == BEATS-1) last_seen++;
      m_beat = (m_beat == BEATS-1) ? 0 : m_beat + 1;
    end
  endtask

  task automatic step(input int pv, input logic [NH-1:0] idle,
                      input int pr, input logic [NH-1:0] en);
    @(negedge clk);
    for (int h = 0; h < NH; h++) begin
      head_in_valid[h] = !idle[h] && ($urandom_range(99) < pv);
      head_in[h*LW +: LW] = LW'($urandom);
    end
    data_out_ready = ($urandom_range(99) < pr);
    head_enable = en;
    #1;
    check_outputs();
    model_update();
  endtask

  task automatic check_reset();
    check("rst_valid", 64'(data_out_valid), 64'(0));
    check("rst_last", 64'(data_out_last), 64'(0));
    check("rst_ready", 64'(head_in_ready), 64'({NH{1'b1}}));
    check("rst_data", 64'(data_out), 64'(0));
  endtask

  initial begin
    int budget;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset();
    @(negedge clk);
    rst = 0;

    for (int c = 0; c < 40; c++) step(100, '0, 100, 2'b11);
    check("aligned_lasts", 64'(last_seen), 64'(1));

    for (int c = 0; c < 10; c++) step(100, 2'b10, 100, 2'b11);
    for (int c = 0; c < 30; c++) step(100, '0, 100, 2'b11);

    for (int c = 0; c < 6; c++) step(100, '0, 0, 2'b11);
    for (int c = 0; c < 20; c++) step(100, '0, 100, 2'b11);

    for (int c = 0; c < 200; c++)
      step(100, 2'b10, 100, 2'b01);
    for (int c = 0; c < 400; c++)
      step(70, NH'($urandom_range(3) == 0 ? 2 : 0), 70,
           NH'($urandom_range(3)));

    budget = 0;
    while (m_beat != 17 && budget < 2000) begin
      step(60, '0, 60, 2'b11);
      budget++;
    end
    check("reach_beat17", 64'(m_beat), 64'(17));
    @(negedge clk);
    rst = 1;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    #1 check_reset();
    rst = 0;
    for (int c = 0; c < 300; c++)
      step(60, '0, 60, NH'($urandom_range(3)));

    check("handshakes_seen", 64'(hs_total > 200), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
